// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// instruction classes, ALU function codes and the PC / write-back mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_JALR   = 3'd7
    } class_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers decide when it applies.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational instruction classifier: opcode/funct3/funct7b5 to class, ALU
// function and an illegal-encoding flag.
module ctrl_opdecode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] op_class,
    output logic [3:0] alu_op,
    output logic       illegal
);

    class_t cls;

    always_comb begin
        cls     = CLS_NONE;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                cls    = CLS_R;
                alu_op = alu_from_funct(funct3, funct7b5);
            end
            OP_I: begin
                // For immediates bit 30 is part of the constant except on shifts-right.
                cls    = CLS_I;
                alu_op = alu_from_funct(funct3, funct7b5 && (funct3 == 3'b101));
            end
            OP_LOAD: begin
                cls     = CLS_LOAD;
                illegal = (funct3 != 3'b010);
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                illegal = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                cls     = CLS_BRANCH;
                alu_op  = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL:  cls = CLS_JAL;
            OP_JALR: cls = CLS_JALR;
            default: illegal = 1'b1;
        endcase
    end

    assign op_class = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// write-back, driving every datapath enable and mux select.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    output logic       imem_req_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_sel_o,
    output logic       alu_src_b_o,
    output logic [3:0] alu_op_o,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic [2:0] state_o
);

    // Memory handshake: a request is raised and held, with dmem_we stable, until
    // ready is sampled high on a clock edge; that edge completes the transfer.
    // ready seen while no request is raised is ignored.

    state_t     state_q, state_d;
    class_t     cls_q;
    logic [2:0] funct3_q;
    logic [3:0] alu_op_q;
    logic       illegal_q;

    logic [2:0] dec_class;
    logic [3:0] dec_alu_op;
    logic       dec_illegal;

    logic       imem_req, ir_write, pc_write, alu_src_b, dmem_req, dmem_we;
    logic       reg_write, retire, taken;
    logic [1:0] pc_sel, wb_sel;
    logic [3:0] alu_op;

    ctrl_opdecode u_opdecode (
        .opcode   (opcode_i),
        .funct3   (funct3_i),
        .funct7b5 (funct7b5_i),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal)
    );

    always_comb begin
        taken = 1'b0;
        case (funct3_q)
            3'b000:  taken = zero_i;
            3'b001:  taken = !zero_i;
            3'b100:  taken = lt_i;
            3'b101:  taken = !lt_i;
            3'b110:  taken = ltu_i;
            3'b111:  taken = !ltu_i;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            funct3_q  <= 3'b000;
            alu_op_q  <= ALU_ADD;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q    <= class_t'(dec_class);
                funct3_q <= funct3_i;
                alu_op_q <= dec_alu_op;
                if (dec_illegal) illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                alu_op    = alu_op_q;
                alu_src_b = (cls_q != CLS_R) && (cls_q != CLS_BRANCH);
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_sel   = taken ? PC_IMM : PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // Address operands stay on the ALU for the whole access.
                alu_op    = alu_op_q;
                alu_src_b = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = (cls_q == CLS_STORE);
                if (dmem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // Operands held from EXEC so the JALR target is still on the ALU output.
                alu_op    = alu_op_q;
                alu_src_b = (cls_q != CLS_R);
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
                case (cls_q)
                    CLS_LOAD:          wb_sel = WB_MEM;
                    CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                    default:           wb_sel = WB_ALU;
                endcase
                case (cls_q)
                    CLS_JAL:  pc_sel = PC_IMM;
                    CLS_JALR: pc_sel = PC_ALU;
                    default:  pc_sel = PC_PLUS4;
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset forces every output low at once, including in-flight requests.
    assign imem_req_o  = imem_req  & ~rst;
    assign ir_write_o  = ir_write  & ~rst;
    assign pc_write_o  = pc_write  & ~rst;
    assign pc_sel_o    = rst ? 2'b00 : pc_sel;
    assign alu_src_b_o = alu_src_b & ~rst;
    assign alu_op_o    = rst ? 4'd0 : alu_op;
    assign dmem_req_o  = dmem_req  & ~rst;
    assign dmem_we_o   = dmem_we   & ~rst;
    assign reg_write_o = reg_write & ~rst;
    assign wb_sel_o    = rst ? 2'b00 : wb_sel;
    assign retire_o    = retire    & ~rst;
    assign illegal_o   = illegal_q & ~rst;
    assign state_o     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push a packed
// expected per-instruction record; a monitor builds the observed record at retire.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int W = 32;

    logic       clk, rst;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i, zero_i, lt_i, ltu_i, imem_ready_i, dmem_ready_i;
    logic       imem_req_o, ir_write_o, pc_write_o, alu_src_b_o, dmem_req_o, dmem_we_o;
    logic       reg_write_o, retire_o, illegal_o;
    logic [1:0] pc_sel_o, wb_sel_o;
    logic [3:0] alu_op_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;
    int iwait = 0;
    int dwait = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .funct7b5_i   (funct7b5_i),
        .zero_i       (zero_i),
        .lt_i         (lt_i),
        .ltu_i        (ltu_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .imem_req_o   (imem_req_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_sel_o     (pc_sel_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .reg_write_o  (reg_write_o),
        .wb_sel_o     (wb_sel_o),
        .retire_o     (retire_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory responders ----------------
    // Ready is raised after iwait/dwait stall cycles; when idle it is held at
    // (wait==0) so ready-without-request is exercised too.
    initial begin
        int iwc = 0;
        int dwc = 0;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!imem_req_o) begin
                iwc = 0;
                imem_ready_i = (iwait == 0);
            end else if (iwc < iwait) begin
                iwc++;
                imem_ready_i = 1'b0;
            end else begin
                imem_ready_i = 1'b1;
            end
            if (!dmem_req_o) begin
                dwc = 0;
                dmem_ready_i = (dwait == 0);
            end else if (dwc < dwait) begin
                dwc++;
                dmem_ready_i = 1'b0;
            end else begin
                dmem_ready_i = 1'b1;
            end
        end
    end

    // ---------------- expected record ----------------
    function automatic logic [W-1:0] mk(input int cyc, input int memc, input logic we,
                                        input logic [3:0] alu, input logic srcb,
                                        input logic [1:0] pcs, input logic [1:0] wbs,
                                        input logic regw);
        logic [7:0] c8;
        logic [3:0] m4;
        c8 = cyc[7:0];
        m4 = memc[3:0];
        return {c8, m4, we, alu, srcb, pcs, wbs, 2'd1, 2'd1, 1'b0, regw, 4'h0};
    endfunction

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : v[1:0];
    endfunction

    // ---------------- monitor ----------------
    int         m_cyc, m_memc, m_irw, m_pcw, m_regw;
    logic       m_we, m_srcb;
    logic [3:0] m_alu;

    initial begin
        logic [W-1:0] obs, exp_v;
        string        nm;
        m_cyc = 0; m_memc = 0; m_irw = 0; m_pcw = 0; m_regw = 0;
        m_we = 1'b0; m_srcb = 1'b0; m_alu = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cyc = 0; m_memc = 0; m_irw = 0; m_pcw = 0; m_regw = 0;
                m_we = 1'b0; m_srcb = 1'b0; m_alu = 4'd0;
            end else begin
                m_cyc++;
                if (dmem_req_o) begin
                    m_memc++;
                    m_we = m_we | dmem_we_o;
                end
                if (state_o == ST_EXEC) begin
                    m_alu  = alu_op_o;
                    m_srcb = alu_src_b_o;
                end
                m_irw  += int'(ir_write_o);
                m_pcw  += int'(pc_write_o);
                m_regw += int'(reg_write_o);
                if (retire_o) begin
                    obs = {m_cyc[7:0], m_memc[3:0], m_we, m_alu, m_srcb, pc_sel_o, wb_sel_o,
                           sat2(m_irw), sat2(m_pcw), sat2(m_regw), 4'h0};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL retire_unexpected got=%h want=none", obs);
                    end else begin
                        exp_v = exp_q.pop_front();
                        nm    = name_q.pop_front();
                        if (obs !== exp_v) begin
                            bad++;
                            $display("FAIL %s got=%h want=%h", nm, obs, exp_v);
                        end
                    end
                    m_cyc = 0; m_memc = 0; m_irw = 0; m_pcw = 0; m_regw = 0;
                    m_we = 1'b0; m_srcb = 1'b0; m_alu = 4'd0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_instr(input logic [31:0] ins, input logic z, input logic l,
                             input logic lu, input int iw, input int dw);
        opcode_i   = ins[6:0];
        funct3_i   = ins[14:12];
        funct7b5_i = ins[30];
        zero_i     = z;
        lt_i       = l;
        ltu_i      = lu;
        iwait      = iw;
        dwait      = dw;
    endtask

    task automatic wait_retire(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (retire_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_retire want=retire", name);
        end
    endtask

    task automatic run(input string name, input logic [31:0] ins, input logic z, input logic l,
                       input logic lu, input int iw, input int dw, input logic [W-1:0] exp_v);
        @(posedge clk);
        #1;
        set_instr(ins, z, l, lu, iw, dw);
        exp_q.push_back(exp_v);
        name_q.push_back(name);
        wait_retire(name);
    endtask

    function automatic logic [31:0] all_outs();
        return {12'h0, imem_req_o, ir_write_o, pc_write_o, pc_sel_o, alu_src_b_o, alu_op_o,
                dmem_req_o, dmem_we_o, reg_write_o, wb_sel_o, retire_o, illegal_o, state_o};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit got;
        rst = 1'b1;
        set_instr(32'h00600513, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        check("reset_outputs_zero", all_outs(), 32'h0);
        rst = 1'b0;
        #1;
        check("fetch_after_reset", {31'h0, imem_req_o}, 32'h1);

        run("addi",      32'h00600513, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_ADD, 1, PC_PLUS4, WB_ALU, 1));
        run("sub",       32'h40d605b3, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_SUB, 0, PC_PLUS4, WB_ALU, 1));
        run("srai",      32'h4030d093, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_SRA, 1, PC_PLUS4, WB_ALU, 1));
        run("andi_b30",  32'h40007013, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_AND, 1, PC_PLUS4, WB_ALU, 1));
        run("addi_iw2",  32'h00600513, 0, 0, 0, 2, 0, mk(6, 0, 0, ALU_ADD, 1, PC_PLUS4, WB_ALU, 1));
        run("lw_dw2",    32'h12302283, 0, 0, 0, 0, 2, mk(7, 3, 0, ALU_ADD, 1, PC_PLUS4, WB_MEM, 1));
        run("sw",        32'h116028a3, 0, 0, 0, 0, 0, mk(4, 1, 1, ALU_ADD, 1, PC_PLUS4, WB_ALU, 0));
        run("beq_t",     32'h00730663, 1, 0, 0, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_IMM,   WB_ALU, 0));
        run("beq_nt",    32'h00730663, 0, 1, 1, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_PLUS4, WB_ALU, 0));
        run("blt_t",     32'h0124c463, 0, 1, 0, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_IMM,   WB_ALU, 0));
        run("blt_nt",    32'h0124c463, 1, 0, 1, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_PLUS4, WB_ALU, 0));
        run("bgeu_t",    32'h00c5f263, 0, 1, 0, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_IMM,   WB_ALU, 0));
        run("bgeu_nt",   32'h00c5f263, 1, 0, 1, 0, 0, mk(3, 0, 0, ALU_SUB, 0, PC_PLUS4, WB_ALU, 0));
        run("jal",       32'h0040036f, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_ADD, 1, PC_IMM,   WB_PC4, 1));
        run("jalr",      32'h000585e7, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_ADD, 1, PC_ALU,   WB_PC4, 1));

        // Reset pulsed during a load wait state.
        @(posedge clk);
        #1;
        set_instr(32'h12302283, 0, 0, 0, 0, 50);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #3;
            if (dmem_req_o) begin
                got = 1'b1;
                break;
            end
        end
        check("midmem_reached", {31'h0, got}, 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midmem_req_drop", all_outs(), 32'h0);
        @(posedge clk);
        #3;
        rst   = 1'b0;
        dwait = 0;
        #1;
        check("midmem_refetch", {29'h0, imem_req_o, state_o[1:0]}, {29'h0, 1'b1, ST_FETCH[1:0]});
        run("addi_after_rst", 32'h00600513, 0, 0, 0, 0, 0, mk(4, 0, 0, ALU_ADD, 1, PC_PLUS4, WB_ALU, 1));

        // Illegal opcode (LUI) traps and stays trapped.
        @(posedge clk);
        #1;
        set_instr(32'h00000037, 0, 0, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (illegal_o) begin
                got = 1'b1;
                break;
            end
        end
        check("trap_entered", {28'h0, got, state_o}, {28'h0, 1'b1, ST_TRAP});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("trap_hold", {29'h0, imem_req_o, retire_o, illegal_o}, 32'h1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("trap_cleared", {28'h0, illegal_o, state_o}, {28'h0, 1'b0, ST_FETCH});

        check("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
